// File: rtl/robo_motion_sequencer.sv
// Motion sequencer for the wall-following decision core: sensor debounce, decide strobe,
// timed motor drive windows, fault latch and completed-move counter.
module robo_motion_sequencer #(
    parameter int unsigned DebCycles  = 4,
    parameter int unsigned AdvCycles  = 16,
    parameter int unsigned TurnCycles = 32,
    parameter int unsigned CntW       = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            head_raw_i,
    input  logic            left_raw_i,
    input  logic            avancar_i,
    input  logic            girar_i,
    output logic            head_o,
    output logic            left_o,
    output logic            decide_o,
    output logic [1:0]      motor_l_o,
    output logic [1:0]      motor_r_o,
    output logic            busy_o,
    output logic            fault_o,
    output logic [CntW-1:0] moves_o
);

    localparam int unsigned DebW = $clog2(DebCycles + 1);

    localparam logic [1:0] MotStop = 2'b00;
    localparam logic [1:0] MotFwd  = 2'b01;
    localparam logic [1:0] MotRev  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StDecide,
        StCapture,
        StAdvance,
        StTurn,
        StFault
    } state_e;

    state_e            state_q;
    logic [1:0]        raw_sens;
    logic [1:0]        filt_q;
    logic [DebW-1:0]   deb_cnt_q [2];
    logic              pending;
    logic [CntW-1:0]   dur_q;
    logic [CntW-1:0]   moves_q;
    logic [1:0]        motor_l_q, motor_r_q;
    logic              decide_q, busy_q, fault_q;

    assign raw_sens = {left_raw_i, head_raw_i};
    assign pending  = (deb_cnt_q[0] != '0) || (deb_cnt_q[1] != '0);

    // Index 0 is the head sensor, index 1 the left sensor.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q       <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw_sens[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebW'(DebCycles - 1)) begin
                    filt_q[i]    <= ~filt_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            dur_q     <= '0;
            moves_q   <= '0;
            motor_l_q <= MotStop;
            motor_r_q <= MotStop;
            decide_q  <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            decide_q <= 1'b0;
            // Dropping enable aborts everything except a latched fault; an aborted move is not counted.
            if (!enable_i && state_q != StFault) begin
                state_q   <= StIdle;
                motor_l_q <= MotStop;
                motor_r_q <= MotStop;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q <= StSettle;
                        busy_q  <= 1'b1;
                    end
                    StSettle: begin
                        if (!pending) begin
                            state_q  <= StDecide;
                            decide_q <= 1'b1;
                        end
                    end
                    StDecide: state_q <= StCapture;
                    StCapture: begin
                        case ({avancar_i, girar_i})
                            2'b10: begin
                                state_q   <= StAdvance;
                                dur_q     <= CntW'(AdvCycles);
                                motor_l_q <= MotFwd;
                                motor_r_q <= MotFwd;
                            end
                            2'b01: begin
                                state_q   <= StTurn;
                                dur_q     <= CntW'(TurnCycles);
                                motor_l_q <= MotFwd;
                                motor_r_q <= MotRev;
                            end
                            default: begin
                                state_q <= StFault;
                                fault_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end
                    StAdvance, StTurn: begin
                        if (dur_q == CntW'(1)) begin
                            state_q   <= StSettle;
                            motor_l_q <= MotStop;
                            motor_r_q <= MotStop;
                            moves_q   <= moves_q + CntW'(1);
                        end else begin
                            dur_q <= dur_q - CntW'(1);
                        end
                    end
                    StFault: begin
                        if (!enable_i) begin
                            state_q <= StIdle;
                            fault_q <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign head_o    = filt_q[0];
    assign left_o    = filt_q[1];
    assign decide_o  = decide_q;
    assign motor_l_o = motor_l_q;
    assign motor_r_o = motor_r_q;
    assign busy_o    = busy_q;
    assign fault_o   = fault_q;
    assign moves_o   = moves_q;

endmodule

// File: tb/tb_robo_motion_sequencer.sv
// Bench for robo_motion_sequencer: directed scenarios with randomized commands, glitch lengths
// and sensor jitter, checked against a sample-history debounce model and move bookkeeping.
module tb_robo_motion_sequencer;

    localparam int Deb  = 4;
    localparam int Adv  = 16;
    localparam int Turn = 32;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       enable_i = 1'b0;
    logic       head_raw_i = 1'b0;
    logic       left_raw_i = 1'b0;
    logic       avancar_i = 1'b0;
    logic       girar_i = 1'b0;
    logic       head_o, left_o, decide_o, busy_o, fault_o;
    logic [1:0] motor_l_o, motor_r_o;
    logic [7:0] moves_o;

    int         vectors = 0;
    int         errs = 0;
    logic       exp_head = 1'b0;
    logic       exp_left = 1'b0;
    logic       hq[$];
    logic       lq[$];
    logic [7:0] exp_moves = 8'd0;

    robo_motion_sequencer #(
        .DebCycles (Deb),
        .AdvCycles (Adv),
        .TurnCycles(Turn),
        .CntW      (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable_i  (enable_i),
        .head_raw_i(head_raw_i),
        .left_raw_i(left_raw_i),
        .avancar_i (avancar_i),
        .girar_i   (girar_i),
        .head_o    (head_o),
        .left_o    (left_o),
        .decide_o  (decide_o),
        .motor_l_o (motor_l_o),
        .motor_r_o (motor_r_o),
        .busy_o    (busy_o),
        .fault_o   (fault_o),
        .moves_o   (moves_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A filtered sensor flips once its last Deb samples all disagree with it.
    task automatic tick();
        int dh, dl;
        @(posedge clk_i);
        #1;
        if (!rst_ni) begin
            hq.delete();
            lq.delete();
            exp_head = 1'b0;
            exp_left = 1'b0;
        end else begin
            hq.push_back(head_raw_i);
            lq.push_back(left_raw_i);
            if (hq.size() > Deb) void'(hq.pop_front());
            if (lq.size() > Deb) void'(lq.pop_front());
            dh = 0;
            dl = 0;
            foreach (hq[i]) if (hq[i] != exp_head) dh++;
            foreach (lq[i]) if (lq[i] != exp_left) dl++;
            if (dh == Deb) begin
                exp_head = ~exp_head;
                hq.delete();
            end
            if (dl == Deb) begin
                exp_left = ~exp_left;
                lq.delete();
            end
        end
        chk("head", 32'(head_o), 32'(exp_head));
        chk("left", 32'(left_o), 32'(exp_left));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_motor_l"}, 32'(motor_l_o), 32'd0);
        chk({tag, "_motor_r"}, 32'(motor_r_o), 32'd0);
        chk({tag, "_decide"}, 32'(decide_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_fault"}, 32'(fault_o), 32'd0);
        chk({tag, "_moves"}, 32'(moves_o), 32'd0);
        chk({tag, "_head"}, 32'(head_o), 32'd0);
        chk({tag, "_left"}, 32'(left_o), 32'd0);
    endtask

    task automatic wait_decide();
        int n = 0;
        while (!decide_o && n < 24) begin
            tick();
            n++;
        end
        chk("decide_seen", 32'(decide_o), 32'd1);
    endtask

    // cmd = {avancar, girar}; jitter randomly toggles the raw sensors during the drive window.
    task automatic do_move(input logic [1:0] cmd, input bit jitter);
        int         len;
        logic [1:0] ml, mr;
        wait_decide();
        {avancar_i, girar_i} = cmd;
        tick();
        chk("capture_decide", 32'(decide_o), 32'd0);
        chk("capture_motor_l", 32'(motor_l_o), 32'd0);
        chk("capture_busy", 32'(busy_o), 32'd1);
        if (cmd == 2'b10) begin
            len = Adv;
            ml  = 2'b01;
            mr  = 2'b01;
        end else if (cmd == 2'b01) begin
            len = Turn;
            ml  = 2'b01;
            mr  = 2'b10;
        end else begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("fault_flag", 32'(fault_o), 32'd1);
                chk("fault_motor_l", 32'(motor_l_o), 32'd0);
                chk("fault_motor_r", 32'(motor_r_o), 32'd0);
                chk("fault_busy", 32'(busy_o), 32'd0);
            end
            return;
        end
        for (int i = 0; i < len; i++) begin
            tick();
            chk("drive_motor_l", 32'(motor_l_o), 32'(ml));
            chk("drive_motor_r", 32'(motor_r_o), 32'(mr));
            chk("drive_busy", 32'(busy_o), 32'd1);
            if (jitter && $urandom_range(0, 3) == 0) head_raw_i = ~head_raw_i;
            if (jitter && $urandom_range(0, 3) == 0) left_raw_i = ~left_raw_i;
        end
        tick();
        exp_moves = exp_moves + 8'd1;
        chk("end_motor_l", 32'(motor_l_o), 32'd0);
        chk("end_motor_r", 32'(motor_r_o), 32'd0);
        chk("end_moves", 32'(moves_o), 32'(exp_moves));
        chk("end_busy", 32'(busy_o), 32'd1);
    endtask

    initial begin
        int g;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Enable rises at cycle 0: settle at 1, decide at 2, advance move.
        enable_i  = 1'b1;
        avancar_i = 1'b1;
        tick();
        chk("lat_settle_busy", 32'(busy_o), 32'd1);
        chk("lat_settle_decide", 32'(decide_o), 32'd0);
        tick();
        chk("lat_decide", 32'(decide_o), 32'd1);
        do_move(2'b10, 1'b0);

        // Held head_raw appears after Deb cycles; then a turn.
        enable_i = 1'b0;
        tick();
        chk("idle2_busy", 32'(busy_o), 32'd0);
        head_raw_i = 1'b1;
        for (int i = 1; i < Deb; i++) begin
            tick();
            chk("head_lag", 32'(head_o), 32'd0);
        end
        tick();
        chk("head_rise", 32'(head_o), 32'd1);
        enable_i = 1'b1;
        tick();
        tick();
        chk("turn_decide_lat", 32'(decide_o), 32'd1);
        do_move(2'b01, 1'b0);

        // Short glitch on head_raw: filtered head holds, settle resumes right after.
        enable_i = 1'b0;
        tick();
        g = $urandom_range(1, Deb - 1);
        enable_i   = 1'b1;
        head_raw_i = 1'b0;
        for (int i = 0; i < g; i++) tick();
        head_raw_i = 1'b1;
        tick();
        chk("glitch_stall", 32'(decide_o), 32'd0);
        tick();
        chk("glitch_decide", 32'(decide_o), 32'd1);
        chk("glitch_head", 32'(head_o), 32'd1);
        do_move(2'b10, 1'b0);

        // Illegal command latches a fault until enable drops.
        do_move(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 1'b0);
        enable_i = 1'b0;
        tick();
        chk("fault_clear", 32'(fault_o), 32'd0);
        chk("fault_exit_busy", 32'(busy_o), 32'd0);

        enable_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            do_move(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 1'b1);
        end

        // Abort at drive cycle 10 of an advance.
        wait_decide();
        {avancar_i, girar_i} = 2'b10;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_drive", 32'(motor_l_o), 32'd1);
        end
        enable_i = 1'b0;
        tick();
        chk("abort_motor_l", 32'(motor_l_o), 32'd0);
        chk("abort_motor_r", 32'(motor_r_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_moves", 32'(moves_o), 32'(exp_moves));

        // Count up to 255, wrap to 0, then reset in the middle of a turn.
        enable_i = 1'b1;
        while (exp_moves != 8'd255) do_move(2'b10, 1'b0);
        do_move(2'b10, 1'b0);
        chk("wrap_moves", 32'(moves_o), 32'd0);
        wait_decide();
        {avancar_i, girar_i} = 2'b01;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("midturn_motor_r", 32'(motor_r_o), 32'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        rst_ni = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
